// File: rtl/control_path_p_if.sv
// control_path_p_if: request/flag inputs plus status and datapath strobe outputs of the y/s control FSM.
interface control_path_p_if #(
    parameter int SW = 4,
    parameter int TW = 2
);
    logic [1:0]    on;
    logic          start;
    logic          it_end;
    logic          abort;
    logic [1:0]    regime;
    logic          active;
    logic          busy;
    logic          done;
    logic [TW-1:0] slot_idx;
    logic [1:0]    y_select_next;
    logic [SW-1:0] s_step;
    logic          s_add;
    logic          s_en;
    logic          s_zero;
    logic          y_en;
    logic          y_store_x;

    modport master (
        output on, start, it_end, abort,
        input  regime, active, busy, done, slot_idx,
        input  y_select_next, s_step, s_add, s_en, s_zero, y_en, y_store_x
    );

    modport slave (
        input  on, start, it_end, abort,
        output regime, active, busy, done, slot_idx,
        output y_select_next, s_step, s_add, s_en, s_zero, y_en, y_store_x
    );
endinterface

// File: rtl/control_path_p.sv
// control_path_p: OFF/ENU/CNT/UPD control FSM driving the y/s datapath strobes.
module control_path_p #(
    parameter int SW         = 4,
    parameter int SLOT       = 4,
    parameter int STRIDE     = 2,
    parameter int UPD_ROUNDS = 1,
    localparam int TW        = $clog2(SLOT)
) (
    input logic              clk,
    input logic              rst,
    control_path_p_if.slave  bus
);
    localparam int RW = (UPD_ROUNDS > 1) ? $clog2(UPD_ROUNDS) : 1;

    typedef enum logic [1:0] {OFF, ENU, CNT, UPD} regime_e;

    regime_e       regime_q;
    logic          active_q;
    logic          done_q;
    logic [TW-1:0] timer_q;
    logic [1:0]    act_q;
    logic [RW-1:0] round_q;

    logic slot_end;
    logic last_round;

    assign slot_end   = active_q && bus.start && (timer_q == '0);
    assign last_round = round_q == RW'(UPD_ROUNDS - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regime_q <= OFF;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            timer_q  <= TW'(SLOT - 1);
            act_q    <= '0;
            round_q  <= '0;
        end else if (bus.abort) begin
            regime_q <= OFF;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            timer_q  <= TW'(SLOT - 1);
            act_q    <= '0;
            round_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (regime_q)
                OFF: regime_q <= regime_e'(bus.on);
                ENU: begin
                    if (!active_q) begin
                        active_q <= 1'b1;
                        timer_q  <= TW'(SLOT - 1);
                    end else if (slot_end) begin
                        timer_q <= TW'(SLOT - 1);
                        if (bus.it_end) begin
                            regime_q <= OFF;
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end else if (bus.start) begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                CNT: begin
                    if (!bus.start) begin
                        regime_q <= OFF;
                        done_q   <= 1'b1;
                    end
                end
                UPD: begin
                    act_q <= act_q + 1'b1;
                    if (act_q == 2'd3) begin
                        // A full round of four actions just finished.
                        if (last_round) begin
                            round_q  <= '0;
                            regime_q <= OFF;
                            done_q   <= 1'b1;
                        end else begin
                            round_q <= round_q + 1'b1;
                        end
                    end
                end
                default: regime_q <= OFF;
            endcase
        end
    end

    always_comb begin
        bus.y_select_next = 2'd0;
        bus.s_step        = '0;
        bus.s_add         = 1'b0;
        bus.s_en          = 1'b0;
        bus.s_zero        = 1'b0;
        bus.y_en          = 1'b0;
        bus.y_store_x     = 1'b0;
        if (!bus.abort) begin
            case (regime_q)
                ENU: begin
                    if (!active_q) begin
                        bus.s_zero = 1'b1;
                        bus.s_en   = 1'b1;
                    end else if (slot_end && !bus.it_end) begin
                        bus.s_en   = 1'b1;
                        bus.s_add  = 1'b1;
                        bus.s_step = SW'(STRIDE);
                    end
                end
                CNT: begin
                    bus.s_en          = 1'b1;
                    bus.s_step        = SW'(1);
                    bus.y_select_next = 2'd1;
                    bus.y_en          = bus.it_end;
                end
                UPD: begin
                    bus.y_store_x     = act_q == 2'd0;
                    bus.y_en          = act_q == 2'd0 || act_q == 2'd1;
                    bus.y_select_next = (act_q == 2'd1) ? 2'd3 : 2'd0;
                    bus.s_en          = act_q == 2'd2;
                    bus.s_add         = act_q == 2'd2;
                    bus.s_step        = (act_q == 2'd2) ? SW'(1) : '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.regime   = regime_q;
    assign bus.active   = active_q;
    assign bus.busy     = regime_q != OFF;
    assign bus.done     = done_q;
    assign bus.slot_idx = (regime_q == ENU) ? timer_q : '0;
endmodule

// File: tb/tb_control_path_p.sv
// tb_control_path_p: directed scenarios plus randomized stimulus checked every cycle against a behavioural model.
module tb_control_path_p;
    localparam int SW = 4, SLOT = 4, STRIDE = 2, R = 2, TW = $clog2(SLOT);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_total = 0;
    int n_pass = 0;

    control_path_p_if #(.SW(SW), .TW(TW)) bus ();
    control_path_p #(.SW(SW), .SLOT(SLOT), .STRIDE(STRIDE), .UPD_ROUNDS(R)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: regime, whether ENU has started iterating, cycles elapsed in the current slot,
    // step index within the whole UPD run (0 .. 4*R-1), and the done pulse.
    int mr = 0;
    bit men = 0;
    int mel = 0;
    int mk = 0;
    bit mdone = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst || bus.abort) begin
            mr = 0; men = 0; mel = 0; mk = 0; mdone = 0;
        end else begin
            mdone = 0;
            if (mr == 0) mr = int'(bus.on);
            else if (mr == 1) begin
                if (!men) begin
                    men = 1; mel = 0;
                end else if (bus.start) begin
                    if (mel == SLOT - 1) begin
                        mel = 0;
                        if (bus.it_end) begin mr = 0; men = 0; mdone = 1; end
                    end else mel++;
                end
            end else if (mr == 2) begin
                if (!bus.start) begin mr = 0; mdone = 1; end
            end else begin
                if (mk == 4 * R - 1) begin mk = 0; mr = 0; mdone = 1; end
                else mk++;
            end
        end
    end

    function automatic logic [17:0] expect_out();
        logic [1:0] ys = 0;
        logic [3:0] st = 0;
        logic ad = 0, se = 0, sz = 0, ye = 0, yx = 0;
        logic [TW-1:0] sl = (mr == 1) ? TW'(SLOT - 1 - mel) : '0;
        if (!bus.abort) begin
            if (mr == 1 && !men) begin sz = 1; se = 1; end
            if (mr == 1 && men && bus.start && mel == SLOT - 1 && !bus.it_end) begin
                se = 1; ad = 1; st = 4'(STRIDE);
            end
            if (mr == 2) begin se = 1; st = 1; ys = 1; ye = bus.it_end; end
            if (mr == 3) begin
                yx = (mk % 4 == 0);
                ye = (mk % 4 < 2);
                ys = (mk % 4 == 1) ? 2'd3 : 2'd0;
                se = (mk % 4 == 2);
                ad = se;
                st = se ? 4'd1 : 4'd0;
            end
        end
        return {2'(mr), men, mr != 0, mdone, sl, ys, st, ad, se, sz, ye, yx};
    endfunction

    always @(negedge clk) begin
        logic [17:0] e, a;
        e = expect_out();
        a = {bus.regime, bus.active, bus.busy, bus.done, bus.slot_idx, bus.y_select_next,
             bus.s_step, bus.s_add, bus.s_en, bus.s_zero, bus.y_en, bus.y_store_x};
        n_total++;
        if (a !== e) $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, a, e);
        else n_pass++;
    end

    task automatic chk(input string nm, input int got, input int want);
        n_total++;
        if (got != want) $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, got, want);
        else n_pass++;
    endtask

    task automatic tick(input logic [1:0] o, input logic s, input logic e, input logic a);
        @(posedge clk);
        #1;
        bus.on = o; bus.start = s; bus.it_end = e; bus.abort = a;
        #1;
    endtask

    int sa[7] = '{1, 0, 0, 0, 1, 1, 1};
    int xa[7] = '{3, 2, 2, 2, 2, 1, 0};

    initial begin
        bus.on = 0; bus.start = 0; bus.it_end = 0; bus.abort = 0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("reset_regime", bus.regime, 0);
        chk("reset_done", bus.done, 0);

        tick(1, 1, 0, 0);
        chk("enu_off_first", bus.regime, 0);
        tick(0, 1, 0, 0);
        chk("enu_szero", bus.s_zero, 1);
        chk("enu_entry_slot", bus.slot_idx, 3);
        for (int k = 0; k < 7; k++) begin
            tick(0, sa[k][0], 0, 0);
            chk("enu_pause_slot", bus.slot_idx, xa[k]);
            chk("enu_pause_sen", bus.s_en, k == 6);
        end
        chk("enu_step", bus.s_step, 2);
        for (int i = 3; i >= 0; i--) begin
            tick(0, 1, 0, 0);
            chk("enu_slot", bus.slot_idx, i);
            chk("enu_sen", bus.s_en, i == 0);
        end
        for (int i = 3; i >= 0; i--) begin
            tick(0, 1, 1, 0);
            chk("enu_last_sen", bus.s_en, 0);
        end
        tick(0, 1, 0, 0);
        chk("enu_exit", bus.regime, 0);
        chk("enu_done", bus.done, 1);
        tick(0, 0, 0, 0);
        chk("enu_done_clr", bus.done, 0);

        tick(2, 1, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            tick(0, c <= 5, c == 3, 0);
            chk("cnt_sen", bus.s_en, 1);
            chk("cnt_yen", bus.y_en, c == 3);
        end
        tick(0, 0, 0, 0);
        chk("cnt_exit", bus.regime, 0);
        chk("cnt_done", bus.done, 1);

        tick(3, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            tick(0, 0, 0, 0);
            chk("upd_regime", bus.regime, 3);
            chk("upd_store", bus.y_store_x, k % 4 == 0);
            chk("upd_ysel", bus.y_select_next, (k % 4 == 1) ? 3 : 0);
            chk("upd_sen", bus.s_en, k % 4 == 2);
        end
        tick(0, 0, 0, 0);
        chk("upd_exit", bus.regime, 0);
        chk("upd_done", bus.done, 1);

        tick(3, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        chk("abort_sen", bus.s_en, 0);
        tick(3, 0, 0, 0);
        chk("abort_off", bus.regime, 0);
        chk("abort_nodone", bus.done, 0);
        tick(0, 0, 0, 0);
        chk("abort_restart", bus.y_store_x, 1);
        tick(0, 0, 0, 0);
        chk("rst_pre_yen", bus.y_en, 1);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_regime", bus.regime, 0);
        chk("rst_async_yen", bus.y_en, 0);
        chk("rst_async_ysel", bus.y_select_next, 0);
        chk("rst_async_busy", bus.busy, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick(0, 0, 0, 0);
        chk("rst_stay_off", bus.regime, 0);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst = ($urandom % 300) != 0;
            bus.on = 2'($urandom);
            bus.start = ($urandom % 10) != 0;
            bus.it_end = ($urandom % 5) == 0;
            bus.abort = ($urandom % 50) == 0;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
